// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and bank-select helper for the 2D FIR line-buffer path.
package fir_pkg;

  localparam int unsigned X_W       = 11;
  localparam int unsigned Y_W       = 11;
  localparam int unsigned BANKS     = 4;
  localparam int unsigned KERNEL    = BANKS + 1;
  localparam int unsigned MAX_WIDTH = 2000;
  localparam int unsigned PAD_LINES = (KERNEL - 1) / 2;
  localparam int unsigned OUT_DLY   = 2;
  localparam int unsigned SEL_W     = $clog2(BANKS);

  typedef enum logic [1:0] {
    StWaitVs = 2'd0,
    StFill   = 2'd1,
    StRun    = 2'd2,
    StFlush  = 2'd3
  } state_e;

  // One-hot write enable for the bank holding line y (y mod BANKS).
  function automatic logic [BANKS-1:0] bank_onehot(input logic [SEL_W-1:0] y);
    logic [BANKS-1:0] oh;
    oh    = '0;
    oh[y] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sync_edge_delay.sv
// Rising-edge detector plus a Dly-deep shift register for one video sync signal.
module sync_edge_delay #(
  parameter int unsigned Dly = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_edge,
  output logic o_dly
);

  logic           r_q;
  logic [Dly-1:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q  <= 1'b0;
      r_sr <= '0;
    end else begin
      r_q  <= i_sig;
      r_sr <= (r_sr << 1) | Dly'(i_sig);
    end
  end

  assign o_edge = i_sig & ~r_q;
  assign o_dly  = r_sr[Dly-1];

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer for the 5x5 FIR window: tracks pixel/line position from the
// video syncs and drives bank writes, addresses, zero padding and window-valid.
module line_buffer_ctrl
  import fir_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [BANKS-1:0] bank_we,
  output logic [X_W-1:0]   wr_addr,
  output logic [X_W-1:0]   rd_addr,
  output logic [SEL_W-1:0] rot_sel,
  output logic             pad_sel,
  output logic [X_W-1:0]   x_index,
  output logic [Y_W-1:0]   y_index,
  output logic             win_valid,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [X_W-1:0]   line_width,
  output logic [Y_W-1:0]   frame_height,
  output logic             ovf_err
);

  localparam logic [X_W-1:0] MaxX      = X_W'(MAX_WIDTH);
  localparam logic [X_W-1:0] KernXLast = X_W'(KERNEL - 1);
  localparam logic [Y_W-1:0] YFillLast = Y_W'(KERNEL - 2);
  localparam logic [1:0]     FlLast    = 2'(PAD_LINES - 1);

  state_e               r_state, w_state_d;
  logic [X_W-1:0]       r_x, w_x_d;
  logic [Y_W-1:0]       r_y, w_y_d;
  logic [X_W-1:0]       r_lw, w_lw_d;
  logic [Y_W-1:0]       r_fh, w_fh_d;
  logic                 r_ovf, w_ovf_d;
  logic [1:0]           r_fl, w_fl_d;
  logic [BANKS-1:0]     r_we;
  logic [X_W-1:0]       r_addr;
  logic [SEL_W-1:0]     r_rot;
  logic                 r_pad;
  logic [OUT_DLY-1:0]   r_dv_sr, r_win_sr;
  logic                 w_hs_edge, w_vs_edge;
  logic                 w_dv_int, w_wr_en, w_win;

  sync_edge_delay #(.Dly(OUT_DLY)) u_hs_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_sig   (hs_i),
    .o_edge  (w_hs_edge),
    .o_dly   (hs_o)
  );

  sync_edge_delay #(.Dly(OUT_DLY)) u_vs_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_sig   (vs_i),
    .o_edge  (w_vs_edge),
    .o_dly   (vs_o)
  );

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_lw_d    = r_lw;
    w_fh_d    = r_fh;
    w_ovf_d   = r_ovf;
    w_fl_d    = r_fl;
    w_dv_int  = 1'b0;
    w_wr_en   = 1'b0;
    w_win     = 1'b0;
    if (w_vs_edge) w_ovf_d = 1'b0;

    unique case (r_state)
      StWaitVs: begin
        if (w_vs_edge) begin
          w_state_d = StFill;
          w_x_d     = '0;
          w_y_d     = '0;
        end
      end
      StFill, StRun: begin
        if (w_vs_edge) begin
          // vs beats a coincident hs; the width of the closing line is still kept.
          if (w_hs_edge) w_lw_d = r_x;
          w_x_d = '0;
          if (r_state == StRun) begin
            w_fh_d    = r_y + Y_W'(1);
            w_y_d     = r_y + Y_W'(1);
            w_fl_d    = '0;
            w_state_d = StFlush;
          end else begin
            w_y_d = '0;
          end
        end else if (w_hs_edge) begin
          w_lw_d = r_x;
          w_x_d  = '0;
          w_y_d  = r_y + Y_W'(1);
          if (r_state == StFill && r_y == YFillLast) w_state_d = StRun;
        end else if (dv_i) begin
          w_dv_int = 1'b1;
          if (r_x == MaxX) begin
            w_ovf_d = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            w_x_d   = r_x + X_W'(1);
            w_win   = (r_state == StRun) && (r_x >= KernXLast);
          end
        end
      end
      StFlush: begin
        if (dv_i) begin
          w_ovf_d   = 1'b1;
          w_state_d = StFill;
          w_x_d     = '0;
          w_y_d     = '0;
        end else if (r_lw == '0) begin
          w_state_d = StFill;
          w_x_d     = '0;
          w_y_d     = '0;
        end else if (r_x == r_lw) begin
          // Synthetic line-end cycle: no write, advance to the next pad line.
          w_x_d = '0;
          if (r_fl == FlLast) begin
            w_state_d = StFill;
            w_y_d     = '0;
          end else begin
            w_fl_d = r_fl + 2'd1;
            w_y_d  = r_y + Y_W'(1);
          end
        end else begin
          w_dv_int = 1'b1;
          w_wr_en  = 1'b1;
          w_x_d    = r_x + X_W'(1);
        end
      end
      default: w_state_d = StWaitVs;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= StWaitVs;
      r_x      <= '0;
      r_y      <= '0;
      r_lw     <= '0;
      r_fh     <= '0;
      r_ovf    <= 1'b0;
      r_fl     <= '0;
      r_we     <= '0;
      r_addr   <= '0;
      r_rot    <= '0;
      r_pad    <= 1'b0;
      r_dv_sr  <= '0;
      r_win_sr <= '0;
    end else begin
      r_state  <= w_state_d;
      r_x      <= w_x_d;
      r_y      <= w_y_d;
      r_lw     <= w_lw_d;
      r_fh     <= w_fh_d;
      r_ovf    <= w_ovf_d;
      r_fl     <= w_fl_d;
      r_we     <= w_wr_en ? bank_onehot(r_y[SEL_W-1:0]) : '0;
      r_addr   <= r_x;
      r_rot    <= r_y[SEL_W-1:0];
      r_pad    <= (r_state == StWaitVs) || (r_state == StFlush);
      r_dv_sr  <= (r_dv_sr << 1) | OUT_DLY'(w_dv_int);
      r_win_sr <= (r_win_sr << 1) | OUT_DLY'(w_win);
    end
  end

  assign bank_we      = r_we;
  assign wr_addr      = r_addr;
  assign rd_addr      = r_addr;
  assign rot_sel      = r_rot;
  assign pad_sel      = r_pad;
  assign x_index      = r_x;
  assign y_index      = r_y;
  assign win_valid    = r_win_sr[OUT_DLY-1];
  assign dv_o         = r_dv_sr[OUT_DLY-1];
  assign line_width   = r_lw;
  assign frame_height = r_fh;
  assign ovf_err      = r_ovf;

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequencer for the 4-bank line-buffer / 5x5 window storage in the 2D FIR path.
- Derives pixel/line coordinates from the video sync inputs and generates the per-bank write enables, write/read addresses and bank-rotation select.
- Generates zero-padding control and end-of-frame flush lines, plus a window-valid flag aligned with the storage outputs for the convolution stage.
- Sits between the video input timing and the storage block.

Parameters:
- X_W, 11, width of the column counter and BRAM address.
- Y_W, 11, width of the line counter.
- BANKS, 4, number of line-buffer banks; power of 2.
- KERNEL, 5, kernel size; must equal BANKS+1.
- MAX_WIDTH, 2000, BRAM depth and maximum active pixels per line.
- PAD_LINES, 2, synthetic zero lines emitted after frame end, equal to (KERNEL-1)/2.
- OUT_DLY, 2, storage read latency that win_valid, dv_o, hs_o and vs_o are aligned to.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- dv_i  in  1  input data valid.
- hs_i  in  1  input horizontal sync; a rising edge starts a new line.
- vs_i  in  1  input vertical sync; a rising edge starts a new frame.
- bank_we  out  BANKS  one-hot bank write enable.
- wr_addr  out  X_W  bank write address.
- rd_addr  out  X_W  bank read address.
- rot_sel  out  log2(BANKS)  bank rotation select, equal to y mod BANKS.
- pad_sel  out  1  forces the pixel mux to 0.
- x_index  out  X_W  current column.
- y_index  out  Y_W  current line.
- win_valid  out  1  5x5 window fully populated, aligned to storage outputs.
- dv_o, hs_o, vs_o  out  1 each  syncs delayed by OUT_DLY.
- line_width  out  X_W  measured active pixels of the last complete line.
- frame_height  out  Y_W  measured line count of the last frame.
- ovf_err  out  1  sticky error flag, cleared on vs edge.

Behaviour:
- Reset (rst=0 at a clk edge): every output and counter is 0, bank_we=0, FSM in WAIT_VS. Reset mid-frame drops the frame; nothing is written until the next vs edge.
- Edge detection: hs_edge = hs_i & ~hs_i_q; vs_edge = vs_i & ~vs_i_q. The sync delay registers are cleared by reset.
- Column counter: x_index increments only on cycles with dv_i=1 in FILL or RUN. On hs_edge, line_width <= x_index and x_index <= 0.
- Line counter: y_index increments on hs_edge.
- Simultaneous hs_edge and vs_edge: vs wins; y_index=0 and x_index=0.
- Write/read path, registered one cycle:
  - wr_addr <= x_index and rd_addr <= x_index.
  - bank_we <= dv_i ? (1 << (y_index mod BANKS)) : 0.
  - rot_sel <= y_index mod BANKS.
  - Wrap: a bank is overwritten every BANKS lines; rot_sel wraps from 3 to 0.
- Overflow: if x_index == MAX_WIDTH while dv_i=1, then bank_we=0, x_index holds, and ovf_err <= 1 until the next vs_edge.
- FSM:
  - WAIT_VS: outputs idle. On vs_edge go to FILL with y_index=0.
  - FILL: lines 0..KERNEL-2 are written; win_valid=0. When y_index reaches KERNEL-1, go to RUN.
  - RUN: win_valid = dv && x_index >= KERNEL-1, delayed by OUT_DLY. On vs_edge: frame_height <= y_index+1, then go to FLUSH.
  - FLUSH: emits PAD_LINES lines of line_width cycles each, with an internal dv, pad_sel=1, writes enabled and rot_sel advancing. Each synthetic line ends with a 1-cycle internal hs pulse. After the last line go to FILL with y_index=0.
  - FLUSH abort: if dv_i=1 during FLUSH, abort the flush, set ovf_err, and go to FILL with y_index=0.
  - FLUSH with zero width: if line_width=0, FLUSH exits immediately.
- pad_sel is 1 in FLUSH and in WAIT_VS, otherwise 0.
- Latency:
  - bank_we, wr_addr, rd_addr and rot_sel trail dv_i by 1 cycle.
  - win_valid, dv_o, hs_o and vs_o trail dv_i by OUT_DLY cycles.

Decomposition:
- Shared package fir_pkg:
  - constants X_W, Y_W, BANKS, KERNEL, MAX_WIDTH.
  - FSM state encoding: WAIT_VS=0, FILL=1, RUN=2, FLUSH=3.
  - function bank_onehot(y).
- Sub-module sync_edge_delay: rising-edge detect plus OUT_DLY shift register, instantiated once per sync signal.

Test Plan:
- Reset, then a vs edge, then 6 lines of 8 pixels:
  - bank_we cycles 0001, 0010, 0100, 1000, 0001, 0010 per line.
  - wr_addr runs 0..7 on each line.
  - win_valid stays 0 through line 3.
  - On lines 4-5, win_valid is 1 for x=4..7, appearing 2 cycles after dv_i.
- After the 6-line frame, a vs edge:
  - frame_height=6, line_width=8.
  - FLUSH emits 2 lines of 8 cycles each with pad_sel=1.
  - FSM then enters FILL.
- hs edge and vs edge in the same cycle, mid-line: y_index=0, x_index=0, FSM in FILL.
- Line of 2001 dv cycles with MAX_WIDTH=2000: bank_we is 0 on the last cycle, ovf_err=1, and ovf_err clears on the next vs edge.
- rst=0 for 1 cycle during RUN: all outputs are 0 on the following cycle, and no bank_we is asserted until a vs edge.
- dv_i asserted during FLUSH: FLUSH aborts, ovf_err=1, FSM in FILL with y_index=0.
